// File: rtl/vram_shadow_bank.sv
// Shadow/active register bank between the CPU data bus and the VGA renderer.
// The CPU writes shadow words at any time. The active copy (ch_out) changes
// only on the first clock after vsync assertion is seen, so the renderer
// never shows a half-updated frame.
module vram_shadow_bank #(
  parameter int unsigned NUM_CH           = 10,
  parameter int unsigned OUT_W            = 11,
  parameter logic [31:0] BASE_ADDR        = 32'h0000_0100,
  parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           we,
  input  logic [31:0]                    adr,
  input  logic [31:0]                    wd,
  output logic [31:0]                    rd,
  output logic                           sel,
  input  logic                           vsync,
  output logic [NUM_CH-1:0][OUT_W-1:0]   ch_out,
  output logic                           commit_pulse,
  output logic [15:0]                    frame_cnt
);

  localparam logic [29:0] CTRL_IDX   = 30'(NUM_CH);
  localparam logic [29:0] STATUS_IDX = 30'(NUM_CH + 1);

  logic [31:0] shadow [NUM_CH];
  logic        pending;
  logic        auto_en;
  logic [29:0] word_idx;
  logic        ctrl_wr;
  logic        vs_level;
  logic        vs_s1, vs_s2, vs_s3;
  logic        vs_start;
  logic        commit;
  logic        unused_adr_bits;

  // Word index relative to channel 0; subtracting the word parts is exact
  // because BASE_ADDR is word aligned and the byte offset is ignored.
  assign word_idx        = adr[31:2] - BASE_ADDR[31:2];
  assign unused_adr_bits = ^adr[1:0];
  assign sel             = (word_idx <= STATUS_IDX);
  assign ctrl_wr         = we && (word_idx == CTRL_IDX);

  assign vs_level = VSYNC_ACTIVE_LOW ? ~vsync : vsync;
  assign vs_start = vs_s2 & ~vs_s3;
  assign commit   = vs_start & (pending | auto_en);

  // Synchronise vsync and keep one stage of history for start detection;
  // reset loads the deasserted level so reset release never looks like a start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_s1 <= 1'b0;
      vs_s2 <= 1'b0;
      vs_s3 <= 1'b0;
    end else begin
      vs_s1 <= vs_level;
      vs_s2 <= vs_s1;
      vs_s3 <= vs_s2;
    end
  end

  // CPU writes to the shadow words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else if (we) begin
      for (int unsigned i = 0; i < NUM_CH; i++)
        if (word_idx == 30'(i)) shadow[i] <= wd;
    end
  end

  // Control state, frame counter and the shadow-to-active copy. The copy
  // reads the shadow array before any same-edge write lands, and pending
  // uses the commit computed from the pre-write AUTO/pending values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_out       <= '0;
      commit_pulse <= 1'b0;
      frame_cnt    <= '0;
      pending      <= 1'b0;
      auto_en      <= 1'b0;
    end else begin
      commit_pulse <= commit;
      pending      <= (ctrl_wr & wd[0]) | (pending & ~commit);
      if (ctrl_wr) auto_en <= wd[1];
      if (vs_start) frame_cnt <= frame_cnt + 16'd1;
      if (commit) begin
        for (int unsigned i = 0; i < NUM_CH; i++) ch_out[i] <= shadow[i][OUT_W-1:0];
      end
    end
  end

  // Combinational read-back mux, zero outside the block's window.
  always_comb begin
    rd = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      if (word_idx == 30'(i)) rd = shadow[i];
    if (word_idx == CTRL_IDX)   rd = {30'b0, auto_en, pending};
    if (word_idx == STATUS_IDX) rd = {frame_cnt, 15'b0, pending};
  end

endmodule
